// File: rtl/ifetch_prefetch_buffer.sv
`timescale 1ns/1ps
// Instruction prefetch queue: streams sequential word fetches from imem into a small
// queue feeding the fetch stage. Define PREFETCH_BYPASS_EN for same-cycle response bypass.
module ifetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_pcplus4_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_req;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_discard;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_resp_pc;
    logic [31:0]    r_instr_mem [DEPTH];
    logic [31:0]    r_pc_mem    [DEPTH];
    logic [31:0]    r_pcp4_mem  [DEPTH];

    logic           w_gnt;
    logic           w_rsp;
    logic           w_drop;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic           w_head_valid;
    logic [31:0]    w_redirect_pc;
    logic [CW-1:0]  w_count_next;
    logic [CW-1:0]  w_outstanding_next;
    logic [CW-1:0]  w_discard_next;
    logic [CW:0]    w_credit_next;

    assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_gnt         = r_req & imem_gnt_i;
    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign w_rsp         = imem_rvalid_i & (r_outstanding != '0);
    assign w_drop        = w_rsp & (r_discard != '0);
    assign w_accept      = w_rsp & (r_discard == '0) & ~redirect_i;
    assign w_head_valid  = (r_count != '0);
    assign w_pop         = w_head_valid & out_ready_i & ~redirect_i;

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_fetch_pc;

`ifdef PREFETCH_BYPASS_EN
    logic w_bypass;

    // An accepted response into an empty queue is shown directly; if taken it never lands.
    assign w_bypass      = rst_n & (r_count == '0) & w_accept;
    assign w_push        = w_accept & ~(w_bypass & out_ready_i);
    assign out_valid_o   = w_head_valid | w_bypass;
    assign out_instr_o   = w_bypass ? imem_rdata_i : r_instr_mem[r_rd_ptr];
    assign out_pc_o      = w_bypass ? r_resp_pc : r_pc_mem[r_rd_ptr];
    assign out_pcplus4_o = w_bypass ? (r_resp_pc + 32'd4) : r_pcp4_mem[r_rd_ptr];
`else
    assign w_push        = w_accept;
    assign out_valid_o   = w_head_valid;
    assign out_instr_o   = r_instr_mem[r_rd_ptr];
    assign out_pc_o      = r_pc_mem[r_rd_ptr];
    assign out_pcplus4_o = r_pcp4_mem[r_rd_ptr];
`endif

    always_comb begin
        w_count_next       = r_count;
        w_outstanding_next = r_outstanding;
        w_discard_next     = r_discard;

        if (redirect_i) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end

        if (w_gnt && !w_rsp) begin
            w_outstanding_next = r_outstanding + CW'(1);
        end else if (!w_gnt && w_rsp) begin
            w_outstanding_next = r_outstanding - CW'(1);
        end

        // Everything still in flight after a redirect belongs to the old stream.
        if (redirect_i) begin
            w_discard_next = w_outstanding_next;
        end else if (w_drop) begin
            w_discard_next = r_discard - CW'(1);
        end

        w_credit_next = {1'b0, w_count_next} + {1'b0, w_outstanding_next};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
        end else begin
            r_count       <= w_count_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;

            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ, S_HOLD: begin
                    // Credit never rises without a grant, so a pending request is never withdrawn.
                    if (w_credit_next >= DEPTH_C) begin
                        r_state <= S_HOLD;
                        r_req   <= 1'b0;
                    end else begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase

            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_gnt) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_accept) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata_i;
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
            r_pcp4_mem[r_wr_ptr]  <= r_resp_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
`timescale 1ns/1ps
// Bench for ifetch_prefetch_buffer: reset/stream vector table, directed corner sequences,
// then randomized traffic checked against a queue-based model of the fetch stream.
module tb_ifetch_prefetch_buffer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_pcplus4_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;

    always #5 clk = ~clk;

    ifetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
        .out_pc_o(out_pc_o), .out_pcplus4_o(out_pcplus4_o), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i)
    );

    // kind: 0 = live, 1 = superseded by a redirect, 2 = issued before a reset (unknown to DUT)
    typedef struct { logic [31:0] addr; int due; int kind; } pend_t;
    typedef struct {
        bit rst_n; bit ready; bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] mq[$];
    int          cyc = 0, n_vec = 0, n_mis = 0;
    int          gnt_prob = 0, ready_prob = 100, dly_min = 1, dly_max = 1;
    bit          drv_rst_n = 1'b0, drv_redir = 1'b0;
    logic [31:0] drv_redir_pc = '0;
    logic [31:0] m_fetch = RPC;
    bit          m_idle = 1'b1, checks_on = 1'b0;
    bit          rsp_now, exp_valid, exp_req, byp;
    logic [31:0] head;
    int          n_gnt = 0, n_pop = 0;
    bit          pop_seen = 1'b0;
    logic [31:0] first_pop_pc = '0;
    vec_t        tbl[8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].kind < 2) n++;
        return n;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic record_pop(input logic [31:0] a);
        n_pop++;
        if (!pop_seen) begin
            pop_seen     = 1'b1;
            first_pop_pc = a;
        end
        $display("cycle %0d pop pc=%h instr=%h", cyc, a, mem_word(a));
    endtask

    task automatic drive_and_check();
        @(negedge clk);
        rst_n         = drv_rst_n;
        redirect_i    = drv_redir;
        redirect_pc_i = drv_redir_pc;
        out_ready_i   = ($urandom_range(99) < ready_prob);
        imem_gnt_i    = ($urandom_range(99) < gnt_prob);
        rsp_now       = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rvalid_i = rsp_now;
        imem_rdata_i  = rsp_now ? mem_word(pend[0].addr) : $urandom();
        byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        if (drv_rst_n && mq.size() == 0 && rsp_now && !drv_redir)
            byp = (pend[0].kind == 0);
`endif
        exp_valid = (mq.size() != 0) || byp;
        head = '0;
        if (mq.size() != 0) head = mq[0];
        else if (byp) head = pend[0].addr;
        exp_req = !m_idle && ((mq.size() + live_cnt()) < DEPTH);
        #1;
        if (checks_on) begin
            chk1("out_valid", out_valid_o, exp_valid);
            chk1("imem_req", imem_req_o, exp_req);
            chk32("imem_addr", imem_addr_o, m_fetch);
            if (exp_valid) begin
                chk32("out_pc", out_pc_o, head);
                chk32("out_pcplus4", out_pcplus4_o, head + 32'd4);
                chk32("out_instr", out_instr_o, mem_word(head));
            end
        end
    endtask

    task automatic commit();
        bit    g;
        int    d;
        pend_t e;
        g = exp_req && imem_gnt_i;
        if (!drv_rst_n) begin
            if (rsp_now) void'(pend.pop_front());
            foreach (pend[i]) pend[i].kind = 2;
            if (g) pend.push_back('{m_fetch, cyc + dly_max, 2});
            mq.delete();
            m_fetch = RPC;
            m_idle  = 1'b1;
        end else begin
            m_idle = 1'b0;
            if (!drv_redir && out_ready_i && mq.size() != 0) record_pop(mq.pop_front());
            if (rsp_now) begin
                e = pend.pop_front();
                if (e.kind == 0 && !drv_redir) begin
                    if (byp && out_ready_i) record_pop(e.addr);
                    else mq.push_back(e.addr);
                end
            end
            if (g) begin
                d = cyc + int'($urandom_range(dly_max, dly_min));
                if (pend.size() > 0 && d < pend[$].due) d = pend[$].due;
                pend.push_back('{m_fetch, d, drv_redir ? 1 : 0});
                n_gnt++;
                if (!drv_redir) m_fetch = m_fetch + 32'd4;
            end
            if (drv_redir) begin
                mq.delete();
                foreach (pend[i]) if (pend[i].kind == 0) pend[i].kind = 1;
                m_fetch = drv_redir_pc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic cycle();
        drive_and_check();
        commit();
    endtask

    task automatic reset_dut();
        drv_redir = 1'b0;
        gnt_prob  = 0;
        for (int i = 0; i < 40 && pend.size() > 0; i++) cycle();
        chk32("drain_before_reset", pend.size(), 0);
        drv_rst_n = 1'b0;
        cycle();
        cycle();
        drv_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then a steady stream: gnt always, 1-cycle memory, fetch always ready.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
`ifdef PREFETCH_BYPASS_EN
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h110};
`else
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
`endif

        drv_rst_n = 1'b0;
        cycle();
        cycle();
        checks_on = 1'b1;

        gnt_prob = 100; dly_min = 1; dly_max = 1;
        for (int i = 0; i < 8; i++) begin
            drv_rst_n  = tbl[i].rst_n;
            ready_prob = tbl[i].ready ? 100 : 0;
            drive_and_check();
            chk1("tbl_req", imem_req_o, tbl[i].exp_req);
            chk32("tbl_addr", imem_addr_o, tbl[i].exp_addr);
            chk1("tbl_valid", out_valid_o, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk32("tbl_pc", out_pc_o, tbl[i].exp_pc);
                chk32("tbl_pcplus4", out_pcplus4_o, tbl[i].exp_pc + 32'd4);
                chk32("tbl_instr", out_instr_o, mem_word(tbl[i].exp_pc));
            end
            $display("vector %0d: req=%b addr=%h valid=%b pc=%h", i, imem_req_o, imem_addr_o, out_valid_o, out_pc_o);
            commit();
        end

        // Fetch stalled: exactly DEPTH grants, then requests stop until a pop frees credit.
        reset_dut();
        gnt_prob = 100; ready_prob = 0; dly_min = 1; dly_max = 1; n_gnt = 0;
        for (int i = 0; i < 12; i++) cycle();
        chk32("full_grants", n_gnt, DEPTH);
        ready_prob = 100; n_pop = 0;
        drive_and_check();
        chk1("full_req_held", imem_req_o, 1'b0);
        commit();
        drive_and_check();
        chk1("full_req_resumed", imem_req_o, 1'b1);
        commit();
        for (int i = 0; i < 20; i++) cycle();
        chk1("full_drain_progress", n_pop >= 10, 1'b1);

        // Redirect with two requests outstanding and no grant in the redirect cycle.
        reset_dut();
        gnt_prob = 100; ready_prob = 100; dly_min = 4; dly_max = 4;
        cycle(); cycle(); cycle();
        gnt_prob = 0; drv_redir = 1'b1; drv_redir_pc = 32'h0000_2003;
        cycle();
        drv_redir = 1'b0; pop_seen = 1'b0; dly_min = 1; dly_max = 3;
        drive_and_check();
        chk32("redir_addr", imem_addr_o, 32'h0000_2000);
        commit();
        gnt_prob = 100;
        for (int i = 0; i < 20; i++) cycle();
        chk1("redir_output_seen", pop_seen, 1'b1);
        chk32("redir_first_pc", first_pop_pc, 32'h0000_2000);

        // Redirect coinciding with a grant and a response.
        reset_dut();
        gnt_prob = 100; ready_prob = 100; dly_min = 1; dly_max = 1;
        for (int i = 0; i < 6; i++) cycle();
        drv_redir = 1'b1; drv_redir_pc = 32'h0000_3000;
        drive_and_check();
        chk1("redir_gnt_req", imem_req_o, 1'b1);
        commit();
        drv_redir = 1'b0; pop_seen = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        chk1("redir_gnt_output_seen", pop_seen, 1'b1);
        chk32("redir_gnt_first_pc", first_pop_pc, 32'h0000_3000);

        // Reset with a queued entry and three requests in flight; late responses are ignored.
        reset_dut();
        gnt_prob = 100; ready_prob = 0; dly_min = 5; dly_max = 5;
        for (int i = 0; i < 7; i++) cycle();
        drv_rst_n = 1'b0;
        cycle();
        drv_rst_n = 1'b1; gnt_prob = 0; ready_prob = 100;
        drive_and_check();
        chk1("rst_valid", out_valid_o, 1'b0);
        chk1("rst_req", imem_req_o, 1'b0);
        commit();
        for (int i = 0; i < 6; i++) begin
            drive_and_check();
            chk1("rst_late_rvalid", out_valid_o, 1'b0);
            commit();
        end
        gnt_prob = 100; dly_min = 1; dly_max = 2; pop_seen = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        chk32("rst_restart_pc", first_pop_pc, RPC);

`ifdef PREFETCH_BYPASS_EN
        // Empty queue: the response is visible in the cycle it arrives and never queued.
        reset_dut();
        gnt_prob = 100; ready_prob = 100; dly_min = 1; dly_max = 1;
        cycle(); cycle();
        gnt_prob = 0;
        drive_and_check();
        chk1("byp_valid", out_valid_o, 1'b1);
        chk32("byp_instr", out_instr_o, mem_word(RPC));
        chk32("byp_pc", out_pc_o, RPC);
        commit();
        drive_and_check();
        chk1("byp_not_queued", out_valid_o, 1'b0);
        commit();
`endif

        // Randomized traffic against the model.
        reset_dut();
        gnt_prob = 70; ready_prob = 70; dly_min = 1; dly_max = 4; n_pop = 0;
        for (int i = 0; i < 1500; i++) begin
            drv_redir    = ($urandom_range(99) < 3);
            drv_redir_pc = $urandom();
            cycle();
        end
        drv_redir = 1'b0;
        chk1("random_progress", n_pop > 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
